// File: rtl/reg_arb_pkg.sv
// reg_arb_pkg: shared definitions for reg_access_arbiter.
//   FS_*        : FunSel encodings understood by the shared 16-bit register
//   arb_state_t : arbiter FSM states
package reg_arb_pkg;

  localparam logic [1:0] FS_DEC  = 2'b00;
  localparam logic [1:0] FS_INC  = 2'b01;
  localparam logic [1:0] FS_LOAD = 2'b10;
  localparam logic [1:0] FS_CLR  = 2'b11;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin priority encoder.
//   i_req  : request vector
//   i_ptr  : index of the last grant; search starts at i_ptr+1 and wraps
//   o_idx  : first requesting index found
//   o_any  : at least one request present
module rr_picker
  import reg_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [ID_W-1:0]    o_idx,
  output logic               o_any
);

  // Walk from farthest to nearest so the nearest hit after i_ptr wins.
  always_comb begin
    int c;
    o_idx = '0;
    o_any = 1'b0;
    c     = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      c = (int'(i_ptr) + k) % NUM_REQ;
      if (i_req[ID_W'(c)]) begin
        o_idx = ID_W'(c);
        o_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_access_arbiter.sv
// reg_access_arbiter: round-robin arbiter sharing one external register
// (E/FunSel/I/Q) among NUM_REQ requesters. Each op: grant (IDLE) ->
// drive register for one cycle (ISSUE) -> capture RegQ and respond (RESP).
//   i_Clock, i_Reset        : clock, asynchronous active-high reset
//   i_ReqValid/FunSel/Data  : per-requester op, slice i belongs to requester i
//   i_ReqLock               : per-requester lock request (REG_ARB_LOCK_EN only)
//   o_ReqReady              : one-hot completion pulse
//   o_RegE/FunSel/I, i_RegQ : shared register interface
//   o_RespValid/Data/Id     : response pulse with post-op register value
//   o_Busy                  : high in ISSUE and RESP
// Optional macro REG_ARB_LOCK_EN: a requester holding ReqLock at RESP is
// re-granted in the next IDLE cycle if it is still requesting.
module reg_access_arbiter
  import reg_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 16,
  parameter int ID_W    = 2
) (
  input  logic                      i_Clock,
  input  logic                      i_Reset,
  input  logic [NUM_REQ-1:0]        i_ReqValid,
  input  logic [2*NUM_REQ-1:0]      i_ReqFunSel,
  input  logic [DATA_W*NUM_REQ-1:0] i_ReqData,
`ifdef REG_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]        i_ReqLock,
`endif
  output logic [NUM_REQ-1:0]        o_ReqReady,
  output logic                      o_RegE,
  output logic [1:0]                o_RegFunSel,
  output logic [DATA_W-1:0]         o_RegI,
  input  logic [DATA_W-1:0]         i_RegQ,
  output logic                      o_RespValid,
  output logic [DATA_W-1:0]         o_RespData,
  output logic [ID_W-1:0]           o_RespId,
  output logic                      o_Busy
);

  arb_state_t          r_state, w_state_nxt;
  logic [ID_W-1:0]     r_ptr, w_ptr_nxt;
  logic [ID_W-1:0]     r_id, w_id_nxt;
  logic [1:0]          w_fs_nxt;
  logic [DATA_W-1:0]   w_data_nxt;
  logic                w_rege_nxt;
  logic [NUM_REQ-1:0]  w_ready_nxt;
  logic                w_rvalid_nxt;
  logic [DATA_W-1:0]   w_rdata_nxt;
  logic [ID_W-1:0]     w_rid_nxt;
  logic                w_busy_nxt;

  logic [ID_W-1:0]     w_pick_idx;
  logic                w_pick_any;
  logic                w_take_lock;
  logic [ID_W-1:0]     w_gnt;
  logic                w_go;

  rr_picker #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
    .i_req (i_ReqValid),
    .i_ptr (r_ptr),
    .o_idx (w_pick_idx),
    .o_any (w_pick_any)
  );

`ifdef REG_ARB_LOCK_EN
  logic r_lock, w_lock_nxt;
  assign w_take_lock = r_lock && i_ReqValid[r_id];
`else
  assign w_take_lock = 1'b0;
`endif

  assign w_gnt = w_take_lock ? r_id : w_pick_idx;
  assign w_go  = w_take_lock | w_pick_any;

  always_comb begin
    w_state_nxt  = r_state;
    w_ptr_nxt    = r_ptr;
    w_id_nxt     = r_id;
    w_fs_nxt     = o_RegFunSel;
    w_data_nxt   = o_RegI;
    w_rege_nxt   = 1'b0;
    w_ready_nxt  = '0;
    w_rvalid_nxt = 1'b0;
    w_rdata_nxt  = o_RespData;
    w_rid_nxt    = o_RespId;
`ifdef REG_ARB_LOCK_EN
    w_lock_nxt   = r_lock;
`endif
    case (r_state)
      IDLE: begin
`ifdef REG_ARB_LOCK_EN
        // Lock is consumed (or dropped) here; RESP re-arms it.
        w_lock_nxt = 1'b0;
`endif
        if (w_go) begin
          w_state_nxt = ISSUE;
          w_id_nxt    = w_gnt;
          // A locked re-grant leaves RR order untouched.
          w_ptr_nxt   = w_take_lock ? r_ptr : w_gnt;
          w_fs_nxt    = i_ReqFunSel[2*int'(w_gnt) +: 2];
          w_data_nxt  = i_ReqData[DATA_W*int'(w_gnt) +: DATA_W];
          w_rege_nxt  = 1'b1;
        end
      end
      ISSUE: begin
        w_state_nxt = RESP;
      end
      RESP: begin
        // The register updated at the ISSUE->RESP edge, so RegQ now holds
        // the post-op value.
        w_state_nxt  = IDLE;
        w_rvalid_nxt = 1'b1;
        w_rdata_nxt  = i_RegQ;
        w_rid_nxt    = r_id;
        w_ready_nxt  = NUM_REQ'(1) << r_id;
`ifdef REG_ARB_LOCK_EN
        w_lock_nxt   = i_ReqLock[r_id];
`endif
      end
      default: w_state_nxt = IDLE;
    endcase
    w_busy_nxt = (w_state_nxt != IDLE);
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_state     <= IDLE;
      r_ptr       <= ID_W'(NUM_REQ - 1);
      r_id        <= '0;
      o_RegE      <= 1'b0;
      o_RegFunSel <= 2'b00;
      o_RegI      <= '0;
      o_ReqReady  <= '0;
      o_RespValid <= 1'b0;
      o_RespData  <= '0;
      o_RespId    <= '0;
      o_Busy      <= 1'b0;
`ifdef REG_ARB_LOCK_EN
      r_lock      <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_id        <= w_id_nxt;
      o_RegE      <= w_rege_nxt;
      o_RegFunSel <= w_fs_nxt;
      o_RegI      <= w_data_nxt;
      o_ReqReady  <= w_ready_nxt;
      o_RespValid <= w_rvalid_nxt;
      o_RespData  <= w_rdata_nxt;
      o_RespId    <= w_rid_nxt;
      o_Busy      <= w_busy_nxt;
`ifdef REG_ARB_LOCK_EN
      r_lock      <= w_lock_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_reg_access_arbiter.sv
// Directed testbench for reg_access_arbiter with a behavioural shared
// register (dec/inc/load/clear) attached to the Reg* interface.
module tb_reg_access_arbiter;
  import reg_arb_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 16;
  localparam int ID_W    = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        reg_rst = 1'b0;
  logic [3:0]  req_valid;
  logic [7:0]  req_fs;
  logic [63:0] req_data;
  logic [3:0]  req_lock;
  logic [3:0]  ready;
  logic        rege;
  logic [1:0]  regfs;
  logic [15:0] regi;
  logic [15:0] reg_q;
  logic        rvalid;
  logic [15:0] rdata;
  logic [1:0]  rid;
  logic        busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  reg_access_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
    .i_Clock     (clk),
    .i_Reset     (rst),
    .i_ReqValid  (req_valid),
    .i_ReqFunSel (req_fs),
    .i_ReqData   (req_data),
`ifdef REG_ARB_LOCK_EN
    .i_ReqLock   (req_lock),
`endif
    .o_ReqReady  (ready),
    .o_RegE      (rege),
    .o_RegFunSel (regfs),
    .o_RegI      (regi),
    .i_RegQ      (reg_q),
    .o_RespValid (rvalid),
    .o_RespData  (rdata),
    .o_RespId    (rid),
    .o_Busy      (busy)
  );

  // Shared register model; its reset is independent of the arbiter's.
  always @(posedge clk or posedge reg_rst) begin
    if (reg_rst) reg_q <= 16'h0000;
    else if (rege) begin
      case (regfs)
        FS_DEC:  reg_q <= reg_q - 16'h0001;
        FS_INC:  reg_q <= reg_q + 16'h0001;
        FS_LOAD: reg_q <= regi;
        default: reg_q <= 16'h0000;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int id, input logic [1:0] fs, input logic [15:0] d);
    req_valid[id]      = 1'b1;
    req_fs[2*id +: 2]  = fs;
    req_data[16*id +: 16] = d;
  endtask

  // Count negedges until RespValid; ReqReady must be one-hot-or-zero throughout.
  task automatic wait_resp(output int lat);
    bit ok;
    ok  = 1'b0;
    lat = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      lat++;
      check("ready_onehot0", 32'($onehot0(ready)), 32'd1);
      if (rvalid === 1'b1) ok = 1'b1;
    end
    check("resp_timeout", 32'(ok), 32'd1);
  endtask

  task automatic run_single(input string tag, input int id, input logic [1:0] fs,
                            input logic [15:0] d, input logic [15:0] exp);
    int lat;
    set_req(id, fs, d);
    wait_resp(lat);
    check({tag, "_lat"},   32'(lat),   32'd3);
    check({tag, "_data"},  32'(rdata), 32'(exp));
    check({tag, "_id"},    32'(rid),   32'(id));
    check({tag, "_ready"}, 32'(ready), 32'(4'b0001 << id));
    req_valid[id] = 1'b0;
    @(negedge clk);
    check({tag, "_rv_low"}, 32'(rvalid), 32'd0);
  endtask

  initial begin
    int lat;
    int exp_id;
    int ids_lock [5];
    req_valid = '0;
    req_fs    = '0;
    req_data  = '0;
    req_lock  = '0;

    // Reset state
    rst = 1'b1; reg_rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_rege",   32'(rege),   32'd0);
    check("rst_regfs",  32'(regfs),  32'd0);
    check("rst_regi",   32'(regi),   32'd0);
    check("rst_ready",  32'(ready),  32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_rdata",  32'(rdata),  32'd0);
    check("rst_rid",    32'(rid),    32'd0);
    check("rst_busy",   32'(busy),   32'd0);
    rst = 1'b0; reg_rst = 1'b0;
    @(negedge clk);

    // Reset during ISSUE: RegE drops at once, register untouched, no response
    set_req(0, FS_LOAD, 16'h5555);
    @(negedge clk);
    check("abort_rege_hi", 32'(rege), 32'd1);
    rst = 1'b1;
    #1;
    check("abort_rege_lo", 32'(rege), 32'd0);
    check("abort_busy",    32'(busy), 32'd0);
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("abort_no_resp",  32'(rvalid), 32'd0);
      check("abort_no_ready", 32'(ready),  32'd0);
      check("abort_no_rege",  32'(rege),   32'd0);
    end
    check("abort_reg_kept", 32'(reg_q), 32'h0000);

    // Single requester 1 load, cycle by cycle
    set_req(1, FS_LOAD, 16'hA5A5);
    @(negedge clk);
    check("issue_rege",   32'(rege),   32'd1);
    check("issue_fs",     32'(regfs),  32'd2);
    check("issue_regi",   32'(regi),   32'hA5A5);
    check("issue_busy",   32'(busy),   32'd1);
    check("issue_rvalid", 32'(rvalid), 32'd0);
    @(negedge clk);
    check("resp_rege",    32'(rege),   32'd0);
    check("resp_rvalid",  32'(rvalid), 32'd0);
    check("resp_busy",    32'(busy),   32'd1);
    @(negedge clk);
    check("done_rvalid",  32'(rvalid), 32'd1);
    check("done_rdata",   32'(rdata),  32'hA5A5);
    check("done_rid",     32'(rid),    32'd1);
    check("done_ready",   32'(ready),  32'b0010);
    check("done_busy",    32'(busy),   32'd0);
    req_valid[1] = 1'b0;
    @(negedge clk);
    check("after_rvalid", 32'(rvalid), 32'd0);
    check("after_ready",  32'(ready),  32'd0);
    check("after_rege",   32'(rege),   32'd0);

    // Wrap passthrough on requester 0
    run_single("clr0", 0, FS_CLR, 16'hBEEF, 16'h0000);
    run_single("dec0", 0, FS_DEC, 16'h1111, 16'hFFFF);
    run_single("inc0", 0, FS_INC, 16'h2222, 16'h0000);

    // All four requesting continuously: order 0,1,2,3,0, 3 cycles apart
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) set_req(i, FS_INC, 16'h0000);
    for (int n = 0; n < 5; n++) begin
      wait_resp(lat);
      exp_id = n % 4;
      check("rr_gap",   32'(lat),   32'd3);
      check("rr_id",    32'(rid),   32'(exp_id));
      check("rr_ready", 32'(ready), 32'(4'b0001 << exp_id));
      check("rr_data",  32'(rdata), 32'(n + 1));
    end
    req_valid = '0;
    @(negedge clk);

    // Clear on 2 and load 1234 on 3, served in RR order
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    set_req(2, FS_CLR,  16'hFFFF);
    set_req(3, FS_LOAD, 16'h1234);
    wait_resp(lat);
    check("mix_id_a",   32'(rid),   32'd2);
    check("mix_data_a", 32'(rdata), 32'h0000);
    req_valid[2] = 1'b0;
    wait_resp(lat);
    check("mix_gap",    32'(lat),   32'd3);
    check("mix_id_b",   32'(rid),   32'd3);
    check("mix_data_b", 32'(rdata), 32'h1234);
    req_valid[3] = 1'b0;
    @(negedge clk);

`ifdef REG_ARB_LOCK_EN
    // Requester 1 locks for three consecutive grants, then RR resumes at 2
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ids_lock = '{0, 1, 1, 1, 2};
    set_req(0, FS_INC, 16'h0000);
    set_req(1, FS_INC, 16'h0000);
    set_req(2, FS_INC, 16'h0000);
    req_lock[1] = 1'b1;
    for (int n = 0; n < 5; n++) begin
      wait_resp(lat);
      check("lock_id",   32'(rid),   32'(ids_lock[n]));
      check("lock_data", 32'(rdata), 32'(16'h1234 + 16'(n + 1)));
      if (n == 2) req_lock[1] = 1'b0;
    end
    req_valid = '0;
    @(negedge clk);
`else
    ids_lock = '{0, 0, 0, 0, 0};
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_access_arbiter.md
Name: reg_access_arbiter

Overview:
- Round-robin arbiter that shares one external 16-bit register (E/FunSel/I/Q interface: dec, inc, load, clear) among NUM_REQ requesters.
- Each requester posts one operation (FunSel + data) with a valid/ready handshake.
- The arbiter grants one requester, drives the register's control inputs for exactly one cycle, then returns the post-operation register value to the granted requester.
- Sits between ALU-system bus masters and a shared Register16bit instance.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 16, register/data width
ID_W, 2, width of requester index (ceil(log2(NUM_REQ)))

Ports:
Clock  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-high reset
ReqValid  input  NUM_REQ  per-requester request pending
ReqFunSel  input  2*NUM_REQ  per-requester op; slice [2i+1:2i] is requester i
ReqData  input  DATA_W*NUM_REQ  per-requester load data; slice i
ReqReady  output  NUM_REQ  one-cycle completion/accept pulse, one-hot or zero
RegE  output  1  enable to shared register
RegFunSel  output  2  FunSel to shared register
RegI  output  DATA_W  data to shared register I
RegQ  input  DATA_W  shared register Q
RespValid  output  1  one-cycle pulse; RespData/RespId valid
RespData  output  DATA_W  register value after the granted op
RespId  output  ID_W  index of requester served
Busy  output  1  high in ISSUE and RESP

Behaviour:
- All outputs are registered. Reset clears them asynchronously: RegE=0, RegFunSel=00, RegI=0, ReqReady=0, RespValid=0, RespData=0, RespId=0, Busy=0.
- Reset forces state IDLE and the RR pointer to NUM_REQ-1, so requester 0 has first priority.
- Reset mid-operation aborts immediately. RegE drops in the same instant, so the register is never written during reset. No response is produced.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - If any ReqValid is high at edge t, pick the first valid index searching from ptr+1 upward with wrap.
  - Latch the id, its FunSel and its Data; set ptr=id; go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE (cycle t+1): RegE=1, RegFunSel and RegI equal the latched values. The register updates at the end of this cycle. Next state is RESP.
- RESP (cycle t+2):
  - RegE=0, RespValid=1, RespData=RegQ sampled in this cycle, RespId=id, ReqReady[id]=1.
  - Next state is IDLE.
- Latency: request sampled at edge t, response visible at t+2. Throughput is one operation per 3 cycles.
- Handshake: a requester holds ReqValid, ReqFunSel and ReqData stable until it sees ReqReady. Changes before then are ignored, because fields are latched at grant.
  - If ReqValid is still high in the IDLE cycle after RESP, it is treated as a new request.
- Non-granted requesters keep waiting. No request is dropped.
- Fairness: a continuously requesting requester waits at most NUM_REQ-1 grants.
- RegI carries latched data for all ops. It matters to the register only on FunSel=10.
- Arithmetic wrap (0000-1 -> FFFF, FFFF+1 -> 0000) is performed by the register. The arbiter passes RegQ through unmodified.
- ReqValid deasserted during ISSUE/RESP by the granted requester: the operation still completes and is reported.

Optional Feature:
REG_ARB_LOCK_EN
- Defined: adds input ReqLock (NUM_REQ bits).
  - If ReqLock[id] is high in the RESP cycle, a lock flag is set.
  - In the next IDLE cycle, if ReqValid[id] is high, id is granted again regardless of RR order, and ptr is unchanged.
  - If ReqValid[id] is low, the lock clears and RR resumes.
  - The lock clears when ReqLock[id] is low at RESP. Reset clears it.
- Undefined: ReqLock port absent; pure round-robin.

Decomposition:
- Package reg_arb_pkg:
  - FunSel constants FS_DEC=2'b00, FS_INC=2'b01, FS_LOAD=2'b10, FS_CLR=2'b11.
  - State enum type arb_state_t {IDLE, ISSUE, RESP}.
- One sub-module, rr_picker: combinational round-robin priority encoder.
  - Inputs: request vector, pointer.
  - Outputs: grant index, any-valid.

Test Plan:
- Reset mid-ISSUE (assert Reset while RegE=1) -> RegE=0 immediately. After release, no RespValid; state IDLE.
- Single requester 1: FunSel=10, Data=16'hA5A5 -> RegE high exactly one cycle with RegI=A5A5. RespValid at t+2, RespData=A5A5, RespId=1, ReqReady=4'b0010.
- Requester 0: FunSel=00 with register at 0000 -> RespData=FFFF. Then FunSel=01 -> RespData=0000 (wrap passthrough).
- All four requesting continuously after reset -> grant order 0,1,2,3,0. ReqReady pulses exactly 3 cycles apart; never two ReqReady bits high.
- Requester 2 issues FunSel=11 while requester 3 holds FunSel=10/Data=1234 -> served in RR order. Responses are RespData=0000 (id 2), then 1234 (id 3).
- With REG_ARB_LOCK_EN: requester 1 holds ReqLock=1 with 0 and 2 requesting -> three consecutive grants to 1. Dropping ReqLock gives the next grant to 2.
